// File: rtl/r5p_gpr_wbu.sv
// Write-back unit for the GPR file: merges ALU results and one outstanding load into a registered write port.
// Optional feature: define R5P_GPR_WBU_LDFWD_EN to forward load response data straight to decode.
module r5p_gpr_wbu #(
  parameter int AW   = 5,
  parameter int XLEN = 32
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dec_e1,
  input  logic                      dec_e2,
  input  logic [AW-1:0]             dec_rs1,
  input  logic [AW-1:0]             dec_rs2,
  output logic                      stall,
  input  logic                      alu_vld,
  input  logic [AW-1:0]             alu_rd,
  input  logic [XLEN-1:0]           alu_dat,
  input  logic                      ldi_vld,
  input  logic [AW-1:0]             ldi_rd,
  input  logic [2:0]                ldi_f3,
  input  logic [$clog2(XLEN/8)-1:0] ldi_off,
  input  logic                      ldr_vld,
  input  logic [XLEN-1:0]           ldr_dat,
  output logic                      e_rd,
  output logic [AW-1:0]             a_rd,
  output logic [XLEN-1:0]           d_rd,
  input  logic [XLEN-1:0]           gpr_rs1,
  input  logic [XLEN-1:0]           gpr_rs2,
  output logic [XLEN-1:0]           d_rs1,
  output logic [XLEN-1:0]           d_rs2
);

  localparam int OW = $clog2(XLEN/8);

  typedef enum logic {IDLE, PEND} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   ld_rd, ld_rd_nxt;
  logic [2:0]      ld_f3, ld_f3_nxt;
  logic [OW-1:0]   ld_off, ld_off_nxt;

  logic            pend, resp;
  logic            alu_acc, ldi_acc;
  logic            hit_rs1, hit_rs2, hazard_rs;
  logic [XLEN-1:0] ld_dat;

  // Align the addressed bytes to bit 0, then sign/zero-extend by funct3.
  function automatic logic [XLEN-1:0] ext(input logic [2:0] f3, input logic [OW-1:0] off,
                                          input logic [XLEN-1:0] dat);
    logic [XLEN-1:0] sh;
    sh = dat >> {off, 3'b000};
    case (f3)
      3'b000:  return XLEN'($signed(sh[7:0]));
      3'b001:  return XLEN'($signed(sh[15:0]));
      3'b010:  return XLEN'($signed(sh[31:0]));
      3'b100:  return XLEN'(sh[7:0]);
      3'b101:  return XLEN'(sh[15:0]);
      3'b110:  return XLEN'(sh[31:0]);
      default: return sh;
    endcase
  endfunction

  assign pend    = (state == PEND);
  assign resp    = pend & ldr_vld;
  assign ld_dat  = ext(ld_f3, ld_off, ldr_dat);

  assign hit_rs1 = dec_e1 & (dec_rs1 == ld_rd);
  assign hit_rs2 = dec_e2 & (dec_rs2 == ld_rd);

`ifdef R5P_GPR_WBU_LDFWD_EN
  assign hazard_rs = pend & ~ldr_vld & (|ld_rd) & (hit_rs1 | hit_rs2);
`else
  assign hazard_rs = pend & (|ld_rd) & (hit_rs1 | hit_rs2);
`endif

  // The load response owns the write port, so a concurrent ALU result waits a cycle.
  assign stall = (pend & ldr_vld & alu_vld)
               | (pend & ldi_vld & ~ldr_vld)
               | (pend & alu_vld & (alu_rd == ld_rd))
               | hazard_rs;

  assign alu_acc = alu_vld & ~stall;
  assign ldi_acc = ldi_vld & ~stall;

  always_comb begin
    state_nxt  = state;
    ld_rd_nxt  = ld_rd;
    ld_f3_nxt  = ld_f3;
    ld_off_nxt = ld_off;
    if (ldi_acc) begin
      state_nxt  = PEND;
      ld_rd_nxt  = ldi_rd;
      ld_f3_nxt  = ldi_f3;
      ld_off_nxt = ldi_off;
    end else if (resp) begin
      state_nxt  = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ld_rd  <= '0;
      ld_f3  <= '0;
      ld_off <= '0;
    end else begin
      state  <= state_nxt;
      ld_rd  <= ld_rd_nxt;
      ld_f3  <= ld_f3_nxt;
      ld_off <= ld_off_nxt;
    end
  end

  // x0 destinations still update a_rd/d_rd but never raise the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_rd <= 1'b0;
      a_rd <= '0;
      d_rd <= '0;
    end else if (resp) begin
      e_rd <= |ld_rd;
      a_rd <= ld_rd;
      d_rd <= ld_dat;
    end else if (alu_acc) begin
      e_rd <= |alu_rd;
      a_rd <= alu_rd;
      d_rd <= alu_dat;
    end else begin
      e_rd <= 1'b0;
    end
  end

  always_comb begin
    d_rs1 = (e_rd && (a_rd == dec_rs1)) ? d_rd : gpr_rs1;
    d_rs2 = (e_rd && (a_rd == dec_rs2)) ? d_rd : gpr_rs2;
`ifdef R5P_GPR_WBU_LDFWD_EN
    if (resp && (|ld_rd) && (dec_rs1 == ld_rd)) d_rs1 = ld_dat;
    if (resp && (|ld_rd) && (dec_rs2 == ld_rd)) d_rs2 = ld_dat;
`endif
  end

endmodule

// File: tb/tb_r5p_gpr_wbu.sv
// Bench for r5p_gpr_wbu: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_r5p_gpr_wbu;

  localparam int AW   = 5;
  localparam int XLEN = 32;
`ifdef R5P_GPR_WBU_LDFWD_EN
  localparam bit LDFWD = 1'b1;
`else
  localparam bit LDFWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            dec_e1, dec_e2;
  logic [AW-1:0]   dec_rs1, dec_rs2;
  logic            stall;
  logic            alu_vld;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_dat;
  logic            ldi_vld;
  logic [AW-1:0]   ldi_rd;
  logic [2:0]      ldi_f3;
  logic [1:0]      ldi_off;
  logic            ldr_vld;
  logic [XLEN-1:0] ldr_dat;
  logic            e_rd;
  logic [AW-1:0]   a_rd;
  logic [XLEN-1:0] d_rd;
  logic [XLEN-1:0] gpr_rs1, gpr_rs2;
  logic [XLEN-1:0] d_rs1, d_rs2;

  int total = 0;
  int bad   = 0;

  // Reference model: outstanding load descriptor and the expected write-port contents.
  logic            m_pend;
  logic [AW-1:0]   m_rd;
  logic [2:0]      m_f3;
  logic [1:0]      m_off;
  logic            m_we;
  logic [AW-1:0]   m_wa;
  logic [XLEN-1:0] m_wd;

  r5p_gpr_wbu #(.AW(AW), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .dec_e1(dec_e1), .dec_e2(dec_e2), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .stall(stall),
    .alu_vld(alu_vld), .alu_rd(alu_rd), .alu_dat(alu_dat),
    .ldi_vld(ldi_vld), .ldi_rd(ldi_rd), .ldi_f3(ldi_f3), .ldi_off(ldi_off),
    .ldr_vld(ldr_vld), .ldr_dat(ldr_dat),
    .e_rd(e_rd), .a_rd(a_rd), .d_rd(d_rd),
    .gpr_rs1(gpr_rs1), .gpr_rs2(gpr_rs2),
    .d_rs1(d_rs1), .d_rs2(d_rs2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Load extension from plain arithmetic: mask the field, then fold the sign bit.
  function automatic logic [XLEN-1:0] refExt(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [XLEN-1:0] dat);
    logic [XLEN-1:0] w;
    w = dat >> (int'(off) * 8);
    case (f3)
      3'd0:    return ((w & 32'hFF)   ^ 32'h80)   - 32'h80;
      3'd1:    return ((w & 32'hFFFF) ^ 32'h8000) - 32'h8000;
      3'd4:    return w & 32'hFF;
      3'd5:    return w & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic refStall();
    logic hz;
    hz = (m_rd != 0) && ((dec_e1 && dec_rs1 == m_rd) || (dec_e2 && dec_rs2 == m_rd));
    if (LDFWD && ldr_vld) hz = 1'b0;
    return m_pend && ((ldr_vld && alu_vld) || (ldi_vld && !ldr_vld) ||
                      (alu_vld && alu_rd == m_rd) || hz);
  endfunction

  function automatic logic [XLEN-1:0] refRs(input logic [AW-1:0] rs, input logic [XLEN-1:0] gpr);
    if (LDFWD && m_pend && ldr_vld && m_rd != 0 && rs == m_rd) return refExt(m_f3, m_off, ldr_dat);
    if (m_we && m_wa == rs) return m_wd;
    return gpr;
  endfunction

  task automatic clearInputs();
    rst = 1'b0; dec_e1 = 1'b0; dec_e2 = 1'b0; dec_rs1 = '0; dec_rs2 = '0;
    alu_vld = 1'b0; alu_rd = '0; alu_dat = '0;
    ldi_vld = 1'b0; ldi_rd = '0; ldi_f3 = '0; ldi_off = '0;
    ldr_vld = 1'b0; ldr_dat = '0; gpr_rs1 = '0; gpr_rs2 = '0;
  endtask

  // Inputs are set at the falling edge; compare, advance the model, and move to the next falling edge.
  task automatic applyStimulus();
    logic st, resp;
    #1;
    st = refStall();
    checkOutput("stall", stall, st);
    checkOutput("e_rd",  e_rd,  m_we);
    checkOutput("a_rd",  a_rd,  m_wa);
    checkOutput("d_rd",  d_rd,  m_wd);
    checkOutput("d_rs1", d_rs1, refRs(dec_rs1, gpr_rs1));
    checkOutput("d_rs2", d_rs2, refRs(dec_rs2, gpr_rs2));
    if (rst) begin
      m_pend = 1'b0; m_rd = '0; m_f3 = '0; m_off = '0;
      m_we = 1'b0; m_wa = '0; m_wd = '0;
    end else begin
      resp = m_pend && ldr_vld;
      if (resp) begin
        m_we = (m_rd != 0); m_wa = m_rd; m_wd = refExt(m_f3, m_off, ldr_dat);
      end else if (alu_vld && !st) begin
        m_we = (alu_rd != 0); m_wa = alu_rd; m_wd = alu_dat;
      end else begin
        m_we = 1'b0;
      end
      if (ldi_vld && !st) begin
        m_pend = 1'b1; m_rd = ldi_rd; m_f3 = ldi_f3; m_off = ldi_off;
      end else if (resp) begin
        m_pend = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic issueLoad(input logic [AW-1:0] rd, input logic [2:0] f3, input logic [1:0] off);
    ldi_vld = 1'b1; ldi_rd = rd; ldi_f3 = f3; ldi_off = off;
    applyStimulus();
    clearInputs();
  endtask

  initial begin
    clearInputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_pend = 1'b0; m_rd = '0; m_f3 = '0; m_off = '0;
    m_we = 1'b0; m_wa = '0; m_wd = '0;
    applyStimulus();
    rst = 1'b0;
    checkOutput("reset_e_rd", e_rd, 0);
    checkOutput("reset_d_rd", d_rd, 0);
    applyStimulus();

    alu_vld = 1'b1; alu_rd = 5'd5; alu_dat = 32'h1234;
    applyStimulus(); clearInputs();
    checkOutput("alu_e_rd", e_rd, 1);
    checkOutput("alu_a_rd", a_rd, 5);
    checkOutput("alu_d_rd", d_rd, 32'h1234);
    alu_vld = 1'b1; alu_rd = 5'd0; alu_dat = 32'h9999;
    applyStimulus(); clearInputs();
    checkOutput("alu_x0_e_rd", e_rd, 0);

    issueLoad(5'd3, 3'b000, 2'd1);
    ldr_vld = 1'b1; ldr_dat = 32'h0000_8000;
    applyStimulus(); clearInputs();
    checkOutput("lb_a_rd", a_rd, 3);
    checkOutput("lb_d_rd", d_rd, 32'hFFFF_FF80);

    issueLoad(5'd4, 3'b101, 2'd2);
    ldr_vld = 1'b1; ldr_dat = 32'hBEEF_0000;
    applyStimulus(); clearInputs();
    checkOutput("lhu_d_rd", d_rd, 32'h0000_BEEF);

    issueLoad(5'd7, 3'b010, 2'd0);
    dec_e2 = 1'b1; dec_rs2 = 5'd7; gpr_rs2 = 32'h0BAD_0BAD;
    #1 checkOutput("raw_stall", stall, 1);
    applyStimulus();
    ldr_vld = 1'b1; ldr_dat = 32'hCAFE_0055;
    #1 checkOutput("raw_resp_stall", stall, !LDFWD);
    applyStimulus();
    ldr_vld = 1'b0;
    #1 checkOutput("raw_after_stall", stall, 0);
    checkOutput("raw_fwd_rs2", d_rs2, 32'hCAFE_0055);
    applyStimulus(); clearInputs();

    issueLoad(5'd8, 3'b010, 2'd0);
    ldr_vld = 1'b1; ldr_dat = 32'h11; alu_vld = 1'b1; alu_rd = 5'd9; alu_dat = 32'h22;
    #1 checkOutput("port_conflict_stall", stall, 1);
    applyStimulus();
    ldr_vld = 1'b0;
    #1 checkOutput("port_alu_retry_stall", stall, 0);
    checkOutput("port_load_first", d_rd, 32'h11);
    applyStimulus(); clearInputs();
    checkOutput("port_alu_second_a", a_rd, 9);
    checkOutput("port_alu_second_d", d_rd, 32'h22);

    issueLoad(5'd10, 3'b010, 2'd0);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0; ldr_vld = 1'b1; ldr_dat = 32'hDEAD_BEEF;
    #1 checkOutput("stale_resp_stall", stall, 0);
    applyStimulus(); clearInputs();
    checkOutput("stale_resp_e_rd", e_rd, 0);

    issueLoad(5'd11, 3'b010, 2'd0);
    ldr_vld = 1'b1; ldr_dat = 32'h33; ldi_vld = 1'b1; ldi_rd = 5'd12; ldi_f3 = 3'b010;
    #1 checkOutput("b2b_stall", stall, 0);
    applyStimulus(); clearInputs();
    checkOutput("b2b_first_a", a_rd, 11);
    alu_vld = 1'b1; alu_rd = 5'd12; alu_dat = 32'h77;
    #1 checkOutput("b2b_waw_stall", stall, 1);
    applyStimulus(); clearInputs();
    ldr_vld = 1'b1; ldr_dat = 32'h44;
    applyStimulus(); clearInputs();
    checkOutput("b2b_second_a", a_rd, 12);
    applyStimulus();

    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      alu_vld = ($urandom_range(0, 2) == 0);
      alu_rd  = 5'($urandom_range(0, 7));
      alu_dat = $urandom();
      ldi_vld = ($urandom_range(0, 3) == 0);
      ldi_rd  = 5'($urandom_range(0, 7));
      ldi_f3  = 3'($urandom_range(0, 7));
      ldi_off = 2'($urandom_range(0, 3));
      ldr_vld = ($urandom_range(0, 2) == 0);
      ldr_dat = $urandom();
      dec_e1  = 1'($urandom_range(0, 1));
      dec_e2  = 1'($urandom_range(0, 1));
      dec_rs1 = 5'($urandom_range(0, 7));
      dec_rs2 = 5'($urandom_range(0, 7));
      gpr_rs1 = $urandom();
      gpr_rs2 = $urandom();
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
